// File: rtl/ili934x_pkg.sv
// ILI934x shared types: stream item, sequencer ROM entry, sequencer
// states and the standard panel init program.
package ili934x_pkg;

  typedef struct packed {
    logic       is_cmd;
    logic [7:0] byte_pack;
  } wr_item_t;

  typedef enum logic [1:0] {
    OP_CMD   = 2'd0,
    OP_DATA  = 2'd1,
    OP_DELAY = 2'd2,
    OP_END   = 2'd3
  } seq_op_e;

  typedef struct packed {
    seq_op_e    op;
    logic [7:0] arg;
  } seq_entry_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EMIT,
    S_WAIT,
    S_DONE,
    S_ERR
  } seq_st_e;

  localparam int FAST_TICK = 16;

  localparam int INIT_LEN = 11;

  // SWRESET, SLPOUT, 16bpp, BGR/MX, DISPON with settle delays
  localparam seq_entry_t [0:INIT_LEN-1] INIT_PROG = '{
    '{OP_CMD,   8'h01},
    '{OP_DELAY, 8'd5},
    '{OP_CMD,   8'h11},
    '{OP_DELAY, 8'd120},
    '{OP_CMD,   8'h3A},
    '{OP_DATA,  8'h55},
    '{OP_CMD,   8'h36},
    '{OP_DATA,  8'h48},
    '{OP_CMD,   8'h29},
    '{OP_DELAY, 8'd20},
    '{OP_END,   8'h00}
  };

  function automatic seq_entry_t mk_entry(
    input seq_op_e    op,
    input logic [7:0] arg
  );
    seq_entry_t e;
    e.op  = op;
    e.arg = arg;
    return e;
  endfunction

endpackage

// File: rtl/ili934x_ms_tick.sv
// Millisecond prescaler: counts while enabled, pulses tick on the
// last cycle of each period, and restarts from zero on clear.
module ili934x_ms_tick #(
  parameter int TICK = 50_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int TW = (TICK > 1) ? $clog2(TICK) : 1;

  logic [TW-1:0] tick_cnt;

  assign tick = en && (tick_cnt == TW'(TICK - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clr || tick) begin
      tick_cnt <= '0;
    end else if (en) begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

endmodule

// File: rtl/ili934x_seq_player.sv
// Table-driven ILI934x command/data/delay player fed from a sync ROM.
// ILI934X_SEQ_FAST_SIM_EN shortens the 1 ms tick to 16 cycles.
module ili934x_seq_player
  import ili934x_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output logic [AW-1:0]                 rom_addr,
  input  logic [$bits(seq_entry_t)-1:0] rom_data,
  output logic                          item_valid,
  output wr_item_t                      item,
  input  logic                          item_ready
);

`ifdef ILI934X_SEQ_FAST_SIM_EN
  localparam int TICK = FAST_TICK;
`else
  localparam int TICK = CLK_HZ / 1000;
`endif

  seq_st_e    st, st_d;
  seq_entry_t entry;
  wr_item_t   item_d;
  logic [AW-1:0] addr_d;
  logic [7:0] ms_cnt, ms_d;
  logic       busy_d, done_d, error_d, iv_d;
  logic       adv, tick, last;

  assign entry = seq_entry_t'(rom_data);
  assign last  = (rom_addr == AW'(DEPTH - 1));

  ili934x_ms_tick #(
    .TICK (TICK)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (st != S_WAIT),
    .en    (st == S_WAIT),
    .tick  (tick)
  );

  always_comb begin
    st_d    = st;
    busy_d  = busy;
    done_d  = done;
    error_d = error;
    iv_d    = item_valid;
    item_d  = item;
    addr_d  = rom_addr;
    ms_d    = ms_cnt;
    adv     = 1'b0;
    unique case (st)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          addr_d  = '0;
          done_d  = 1'b0;
          error_d = 1'b0;
          busy_d  = 1'b1;
          st_d    = S_FETCH;
        end
      end
      S_FETCH: st_d = S_DECODE;
      S_DECODE: begin
        unique case (entry.op)
          OP_CMD, OP_DATA: begin
            item_d.is_cmd    = (entry.op == OP_CMD);
            item_d.byte_pack = entry.arg;
            iv_d             = 1'b1;
            st_d             = S_EMIT;
          end
          OP_DELAY: begin
            if (entry.arg == 8'd0) begin
              adv = 1'b1;
            end else begin
              ms_d = entry.arg;
              st_d = S_WAIT;
            end
          end
          OP_END: begin
            done_d = 1'b1;
            busy_d = 1'b0;
            st_d   = S_DONE;
          end
        endcase
      end
      S_EMIT: begin
        if (item_ready) begin
          iv_d = 1'b0;
          adv  = 1'b1;
        end
      end
      S_WAIT: begin
        if (tick) begin
          ms_d = ms_cnt - 8'd1;
          adv  = (ms_cnt == 8'd1);
        end
      end
      default: st_d = S_IDLE;
    endcase
    // running off the end of the table is an overrun, not a wrap
    if (adv) begin
      if (last) begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        st_d    = S_ERR;
      end else begin
        addr_d = rom_addr + AW'(1);
        st_d   = S_FETCH;
      end
    end
    // abort beats start and any advance; sticky flags survive it
    if (abort) begin
      st_d    = (st inside {S_FETCH, S_DECODE, S_EMIT, S_WAIT}) ? S_IDLE : st;
      busy_d  = 1'b0;
      iv_d    = 1'b0;
      done_d  = done;
      error_d = error;
      addr_d  = rom_addr;
      ms_d    = ms_cnt;
      item_d  = item;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      item_valid <= 1'b0;
      item       <= '0;
      rom_addr   <= '0;
      ms_cnt     <= '0;
    end else begin
      st         <= st_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
      item_valid <= iv_d;
      item       <= item_d;
      rom_addr   <= addr_d;
      ms_cnt     <= ms_d;
    end
  end

endmodule

// File: tb/tb_ili934x_seq_player.sv
// Scoreboard bench for ili934x_seq_player: random programs and
// backpressure checked against a cycle-cost model of the program.
module tb_ili934x_seq_player;
  import ili934x_pkg::*;

  localparam int DEPTH  = 16;
  localparam int CLK_HZ = 16_000;
  localparam int AW     = $clog2(DEPTH);
`ifdef ILI934X_SEQ_FAST_SIM_EN
  localparam int TICK = 16;
`else
  localparam int TICK = CLK_HZ / 1000;
`endif

  logic clk = 0;
  logic rst_n = 0;
  logic start = 0;
  logic abort = 0;
  logic item_ready = 0;
  logic busy, done, error, item_valid;
  logic [AW-1:0] rom_addr;
  seq_entry_t rom_data;
  wr_item_t item;

  seq_entry_t mem [DEPTH];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [8:0] it;
    int         t;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_data <= mem[rom_addr];
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 0) item_ready = 1'b1;
    else if (rdy_mode == 1) item_ready = ($urandom_range(0, 99) >= 30);
    else item_ready = 1'b0;
  end

  ili934x_seq_player #(
    .CLK_HZ (CLK_HZ),
    .DEPTH  (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .item_valid (item_valid),
    .item       (item),
    .item_ready (item_ready)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every fire, checks hold on stall
  logic pst = 0;
  logic pab = 0;
  wr_item_t pit;
  always @(negedge clk) begin
    if (pst && !pab && rst_n) begin
      total++;
      if (!item_valid || item !== pit) begin
        bad++;
        $display("FAIL hold: valid=%0b item=%h expected valid=1 item=%h",
                 item_valid, item, pit);
      end
    end
    if (rst_n && item_valid && item_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL extra_item: got %h expected none", item);
      end else begin
        me = sb.pop_front();
        if (item !== me.it || (me.t >= 0 && cyc + 1 != me.t)) begin
          bad++;
          $display("FAIL item: got %h at edge %0d expected %h at %0d",
                   item, cyc + 1, me.it, me.t);
        end
      end
    end
    pst = rst_n && item_valid && !item_ready;
    pit = item;
    pab = abort;
  end

  // each entry costs fetch+decode (2) plus: emit 1, delay n*TICK, delay0 0
  task automatic model(input int s, input bit timed, input int limit,
                       output bit xd, output bit xe);
    int f;
    exp_t e;
    f = s;
    xd = 0;
    for (int a = 0; a < DEPTH; a++) begin
      if (mem[a].op == OP_END) begin
        xd = 1;
        break;
      end else if (mem[a].op == OP_DELAY) begin
        f += (mem[a].arg == 0) ? 2 : 2 + int'(mem[a].arg) * TICK;
      end else begin
        e.it = {mem[a].op == OP_CMD, mem[a].arg};
        e.t  = timed ? f + 3 : -1;
        if (f + 3 < limit) sb.push_back(e);
        f += 3;
      end
    end
    xe = !xd;
  endtask

  task automatic kick(output int s);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    s = cyc;
    chk("start_busy", busy, 1);
    chk("start_done_clr", done, 0);
    chk("start_err_clr", error, 0);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL timeout: busy=1 after %0d cycles expected 0", budget);
    end
  endtask

  task automatic finish_run(input bit xd, input bit xe);
    wait_idle(20000);
    repeat (3) begin @(posedge clk); #1; end
    chk("done", done, xd);
    chk("error", error, xe);
    chk("busy_end", busy, 0);
    chk("valid_end", item_valid, 0);
    chk("sb_drained", sb.size(), 0);
    sb.delete();
  endtask

  task automatic load_init();
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (i < INIT_LEN) ? INIT_PROG[i] : mk_entry(OP_END, 8'h00);
  endtask

  task automatic load_rand(input bit with_end);
    int l, r;
    l = $urandom_range(3, DEPTH - 2);
    for (int i = 0; i < DEPTH; i++) begin
      r = $urandom_range(0, 9);
      if (with_end && i >= l) mem[i] = mk_entry(OP_END, 8'h00);
      else if (r < 4) mem[i] = mk_entry(OP_CMD, 8'($urandom));
      else if (r < 8) mem[i] = mk_entry(OP_DATA, 8'($urandom));
      else mem[i] = mk_entry(OP_DELAY, 8'($urandom_range(0, 2)));
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    bit xd, xe;
    load_init();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_valid", item_valid, 0);
    chk("rst_item", item, 0);
    chk("rst_addr", rom_addr, 0);
    @(negedge clk) rst_n = 1;

    // init program, ready high, exact timing
    rdy_mode = 0;
    kick(s);
    model(s, 1, 1 << 30, xd, xe);
    finish_run(xd, xe);
    chk("init_addr", rom_addr, INIT_LEN - 1);

    // restart from DONE, plus a stray start while busy
    kick(s);
    model(s, 1, 1 << 30, xd, xe);
    repeat (49) @(posedge clk);
    #1 start = 1;
    @(posedge clk); #1 start = 0;
    finish_run(xd, xe);

    // init program under random backpressure
    rdy_mode = 1;
    kick(s);
    model(s, 0, 1 << 30, xd, xe);
    finish_run(xd, xe);

    // random terminated programs
    for (int k = 0; k < 4; k++) begin
      load_rand(1);
      kick(s);
      model(s, 0, 1 << 30, xd, xe);
      finish_run(xd, xe);
    end

    // overrun: no OP_END in the table
    load_rand(0);
    kick(s);
    model(s, 0, 1 << 30, xd, xe);
    finish_run(xd, xe);
    chk("ovr_addr", rom_addr, DEPTH - 1);
    repeat (40) @(posedge clk);
    #1 chk("ovr_quiet", item_valid, 0);

    // abort inside the 120 ms wait
    load_init();
    rdy_mode = 0;
    kick(s);
    model(s, 1, s + 1000, xd, xe);
    repeat (999) @(posedge clk);
    #1 abort = 1;
    @(posedge clk); #1 abort = 0;
    chk("abort_busy", busy, 0);
    chk("abort_valid", item_valid, 0);
    chk("abort_done", done, 0);
    repeat (20) @(posedge clk);
    #1 chk("abort_sb", sb.size(), 0);

    // start and abort together in IDLE
    @(posedge clk); #1 start = 1; abort = 1;
    @(posedge clk); #1 start = 0; abort = 0;
    chk("sa_busy", busy, 0);
    repeat (5) @(posedge clk);
    #1 chk("sa_idle", busy, 0);
    chk("sa_valid", item_valid, 0);

    // replay after abort restarts at address 0
    kick(s);
    model(s, 1, 1 << 30, xd, xe);
    finish_run(xd, xe);

    // zero-length delay falls straight through to the next entry
    mem[0] = mk_entry(OP_DELAY, 8'd0);
    mem[1] = mk_entry(OP_CMD, 8'hAA);
    mem[2] = mk_entry(OP_END, 8'h00);
    kick(s);
    model(s, 1, 1 << 30, xd, xe);
    repeat (3) @(posedge clk);
    #1 chk("d0_not_yet", item_valid, 0);
    @(posedge clk);
    #1 chk("d0_valid", item_valid, 1);
    finish_run(xd, xe);

    // async reset while an item is stalled
    mem[0] = mk_entry(OP_CMD, 8'h5A);
    mem[1] = mk_entry(OP_END, 8'h00);
    rdy_mode = 2;
    kick(s);
    repeat (5) @(posedge clk);
    #1 chk("emit_valid", item_valid, 1);
    chk("emit_item", item, 9'h15A);
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", item_valid, 0);
    chk("mid_rst_item", item, 0);
    chk("mid_rst_addr", rom_addr, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_error", error, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_busy", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
